// File: rtl/axi_address_responder.sv
// AXI address-channel responder: accepts one AR/AW request at a time and
// walks its burst, presenting one address per beat to a data channel.
// Optional WRAP burst support is built only when AXI_WRAP_BURST_EN is defined;
// otherwise WRAP requests are flagged as errors and use FIXED addressing.
module axi_address_responder #(
    parameter int unsigned DATA_BYTES_LOG2 = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  AxID,
    input  logic [31:0] AxADDR,
    input  logic [7:0]  AxLEN,
    input  logic [2:0]  AxSIZE,
    input  logic [1:0]  AxBURST,
    input  logic        AxVALID,
    output logic        AxREADY,
    output logic        beat_valid,
    input  logic        beat_ready,
    output logic [31:0] beat_addr,
    output logic [3:0]  beat_id,
    output logic [7:0]  beat_count,
    output logic        beat_last,
    output logic        beat_error,
    output logic [1:0]  current_state_out
);

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned IW = 4;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_IDLE  = 2'b01,
        ST_BURST = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        AM_FIXED = 2'b00,
        AM_INCR  = 2'b01,
        AM_WRAP  = 2'b10
    } addr_mode_e;

    state_e       state_q, state_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] id_q, id_d;
    logic [LW-1:0] count_q, count_d;
    logic [LW-1:0] len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    addr_mode_e    mode_q, mode_d;
`ifdef AXI_WRAP_BURST_EN
    logic [AW-1:0] wrap_mask_q, wrap_mask_d;
`endif

    // Request-side decode: size mask, INCR last-beat address and error flag
    logic [AW-1:0] req_size_mask_c;
    logic [AW-1:0] req_incr_last_c;
    logic          req_page_cross_c;
    logic          req_size_err_c;
    logic          req_err_c;
    addr_mode_e    req_mode_c;
`ifdef AXI_WRAP_BURST_EN
    logic          req_wrap_len_ok_c;
    logic          req_wrap_aligned_c;
    logic [AW-1:0] req_wrap_mask_c;
`endif

    // Classify the incoming request and pick its addressing mode
    always_comb begin
        req_size_mask_c  = (AW'(1) << AxSIZE) - AW'(1);
        req_incr_last_c  = (AxADDR & ~req_size_mask_c) + (AW'(AxLEN) << AxSIZE);
        req_page_cross_c = ((AxADDR ^ req_incr_last_c) & 32'hFFFF_F000) != AW'(0);
        req_size_err_c   = 32'(AxSIZE) > DATA_BYTES_LOG2;
        req_err_c        = 1'b1;
        req_mode_c       = AM_FIXED;
`ifdef AXI_WRAP_BURST_EN
        req_wrap_len_ok_c  = (AxLEN == 8'd1) || (AxLEN == 8'd3) ||
                             (AxLEN == 8'd7) || (AxLEN == 8'd15);
        req_wrap_aligned_c = (AxADDR & req_size_mask_c) == AW'(0);
        req_wrap_mask_c    = ((AW'(AxLEN) + AW'(1)) << AxSIZE) - AW'(1);
`endif
        case (AxBURST)
            2'b00: req_err_c = req_size_err_c;
            2'b01: begin
                req_err_c  = req_size_err_c || req_page_cross_c;
                req_mode_c = AM_INCR;
            end
`ifdef AXI_WRAP_BURST_EN
            2'b10: begin
                req_err_c = req_size_err_c || !req_wrap_len_ok_c || !req_wrap_aligned_c;
                if (req_wrap_len_ok_c && req_wrap_aligned_c) begin
                    req_mode_c = AM_WRAP;
                end
            end
`endif
            default: req_err_c = 1'b1;
        endcase
    end

    // Address of the beat following the current one
    logic [AW-1:0] beat_incr_c;
    logic [AW-1:0] next_addr_c;

    always_comb begin
        beat_incr_c = AW'(1) << size_q;
        next_addr_c = addr_q;
        case (mode_q)
            AM_INCR: next_addr_c = (addr_q & ~(beat_incr_c - AW'(1))) + beat_incr_c;
`ifdef AXI_WRAP_BURST_EN
            AM_WRAP: next_addr_c = (addr_q & ~wrap_mask_q) |
                                   ((addr_q + beat_incr_c) & wrap_mask_q);
`endif
            default: next_addr_c = addr_q;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        count_d = count_q;
        len_d   = len_q;
        size_d  = size_q;
        last_d  = last_q;
        err_d   = err_q;
        mode_d  = mode_q;
`ifdef AXI_WRAP_BURST_EN
        wrap_mask_d = wrap_mask_q;
`endif
        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (AxVALID && ready_q) begin
                    state_d = ST_BURST;
                    addr_d  = AxADDR;
                    id_d    = AxID;
                    count_d = '0;
                    len_d   = AxLEN;
                    size_d  = AxSIZE;
                    last_d  = (AxLEN == 8'd0);
                    err_d   = req_err_c;
                    mode_d  = req_mode_c;
`ifdef AXI_WRAP_BURST_EN
                    wrap_mask_d = req_wrap_mask_c;
`endif
                end
            end
            ST_BURST: begin
                if (valid_q && beat_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + 8'd1;
                        last_d  = (count_q + 8'd1) == len_q;
                        addr_d  = next_addr_c;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_BURST);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RESET;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= AM_FIXED;
`ifdef AXI_WRAP_BURST_EN
            wrap_mask_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            count_q <= count_d;
            len_q   <= len_d;
            size_q  <= size_d;
            last_q  <= last_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
`ifdef AXI_WRAP_BURST_EN
            wrap_mask_q <= wrap_mask_d;
`endif
        end
    end

    assign AxREADY           = ready_q;
    assign beat_valid        = valid_q;
    assign beat_addr         = addr_q;
    assign beat_id           = id_q;
    assign beat_count        = count_q;
    assign beat_last         = last_q;
    assign beat_error        = err_q;
    assign current_state_out = state_q;

endmodule
